// File: rtl/instr_decode_stage_if.sv
// Handshake and decoded-field bundle between fetch, the decode stage and register read.
// master drives instructions in and accepts decoded results; slave is the decode stage.
interface instr_decode_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [PC_W-1:0]  in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       out_opcode;
    logic [4:0]       out_rs;
    logic [4:0]       out_rt;
    logic [4:0]       out_rd;
    logic [4:0]       out_shamt;
    logic [5:0]       out_func;
    logic [1:0]       out_fmt;
    logic [XLEN-1:0]  out_imm;
    logic [PC_W-1:0]  out_jtarget;
    logic [PC_W-1:0]  out_pc;
    logic [CNT_W-1:0] out_count;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_shamt,
               out_func, out_fmt, out_imm, out_jtarget, out_pc, out_count
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_shamt,
               out_func, out_fmt, out_imm, out_jtarget, out_pc, out_count
    );
endinterface

// File: rtl/instr_decode_stage.sv
// MIPS instruction decode stage: field split, format/immediate/jump-target decode,
// registered into a 2-entry main/skid buffer with valid/ready flow control.
module instr_decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    instr_decode_stage_if.slave  bus
);
    typedef struct packed {
        logic [5:0]      opcode;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [4:0]      shamt;
        logic [5:0]      func;
        logic [1:0]      fmt;
        logic [XLEN-1:0] imm;
        logic [PC_W-1:0] jtarget;
        logic [PC_W-1:0] pc;
    } entry_t;

    localparam logic [PC_W-1:0] SegMask = PC_W'(32'h0FFF_FFFF);

    entry_t           dec;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PC_W-1:0]  pc_plus4;
    logic [15:0]      imm16;
    logic             accept;
    logic             drain;

    always_comb begin
        dec         = '0;
        dec.opcode  = bus.in_instr[31:26];
        dec.rs      = bus.in_instr[25:21];
        dec.rt      = bus.in_instr[20:16];
        dec.rd      = bus.in_instr[15:11];
        dec.shamt   = bus.in_instr[10:6];
        dec.func    = bus.in_instr[5:0];
        dec.pc      = bus.in_pc;
        imm16       = bus.in_instr[15:0];

        case (bus.in_instr[31:26])
            6'h00:        dec.fmt = 2'b00;
            6'h02, 6'h03: dec.fmt = 2'b10;
            default:      dec.fmt = 2'b01;
        endcase

        // Signed casts widen by sign extension; the lui form extends from bit 31.
        case (bus.in_instr[31:26])
            6'h0C, 6'h0D, 6'h0E: dec.imm = XLEN'(imm16);
            6'h0F:               dec.imm = XLEN'($signed({imm16, 16'h0000}));
            default:             dec.imm = XLEN'($signed(imm16));
        endcase

        pc_plus4    = bus.in_pc + PC_W'(4);
        dec.jtarget = (pc_plus4 & ~SegMask) | PC_W'({bus.in_instr[25:0], 2'b00});
    end

    assign accept = bus.in_valid & ~skid_valid_q & ~bus.flush;
    assign drain  = main_valid_q & bus.out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        count_d      = drain ? count_q + CNT_W'(1) : count_q;

        if (bus.flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || drain) begin
            // Skid is full only when in_ready was low, so it never races a new accept.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            count_q      <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            count_q      <= count_d;
        end
    end

    assign bus.in_ready    = rst_n & ~skid_valid_q & ~bus.flush;
    assign bus.out_valid   = main_valid_q;
    assign bus.out_opcode  = main_q.opcode;
    assign bus.out_rs      = main_q.rs;
    assign bus.out_rt      = main_q.rt;
    assign bus.out_rd      = main_q.rd;
    assign bus.out_shamt   = main_q.shamt;
    assign bus.out_func    = main_q.func;
    assign bus.out_fmt     = main_q.fmt;
    assign bus.out_imm     = main_q.imm;
    assign bus.out_jtarget = main_q.jtarget;
    assign bus.out_pc      = main_q.pc;
    assign bus.out_count   = count_q;
endmodule
